// File: rtl/flopoco_fp_pkg.sv
// Shared FloPoCo float definitions: exception codes, compare predicates,
// stage-1 decode bundle and width-generic field extractors.
package flopoco_fp_pkg;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef enum logic [2:0] {
    OP_EQ    = 3'd0,
    OP_LT    = 3'd1,
    OP_LE    = 3'd2,
    OP_GT    = 3'd3,
    OP_GE    = 3'd4,
    OP_NE    = 3'd5,
    OP_UNORD = 3'd6,
    OP_ORD   = 3'd7
  } fcmp_op_e;

  typedef struct packed {
    logic [1:0] exc_x;
    logic [1:0] exc_y;
    logic       sign_x;
    logic       sign_y;
    logic       lt;
    logic       gt;
  } fcmp_dec_t;

  localparam int FP_RAW_W = 64;
  typedef logic [FP_RAW_W-1:0] fp_raw_t;

  function automatic logic [1:0] fp_exc(
    input fp_raw_t v, input int we, input int wf);
    return v[we+wf+1 +: 2];
  endfunction

  function automatic logic fp_sign(
    input fp_raw_t v, input int we, input int wf);
    return v[we+wf];
  endfunction

  function automatic fp_raw_t fp_mag(
    input fp_raw_t v, input int we, input int wf);
    return v & ((fp_raw_t'(1) << (we + wf)) - fp_raw_t'(1));
  endfunction

endpackage

// File: rtl/flopoco_fcmp_pipe_if.sv
// Operand/result handshake bundle of the float comparator.
// out_min/out_max exist only when FCMP_MINMAX_EN is defined.
interface flopoco_fcmp_pipe_if
  import flopoco_fp_pkg::*;
#(
  parameter int WE    = 4,
  parameter int WF    = 4,
  parameter int TAG_W = 8
);
  localparam int N = WE + WF + 3;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     X;
  logic [N-1:0]     Y;
  fcmp_op_e         op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             unordered;
  logic [TAG_W-1:0] out_tag;
`ifdef FCMP_MINMAX_EN
  logic [N-1:0]     out_min;
  logic [N-1:0]     out_max;
`endif

  modport master (
`ifdef FCMP_MINMAX_EN
    input  out_min, out_max,
`endif
    output in_valid, X, Y, op, in_tag, out_ready,
    input  in_ready, out_valid, result, unordered, out_tag
  );

  modport slave (
`ifdef FCMP_MINMAX_EN
    output out_min, out_max,
`endif
    input  in_valid, X, Y, op, in_tag, out_ready,
    output in_ready, out_valid, result, unordered, out_tag
  );

endinterface

// File: rtl/flopoco_mag_cmp.sv
// Unsigned magnitude comparator on concatenated {exp,frac}.
module flopoco_mag_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         gt
);

  assign lt = a < b;
  assign gt = a > b;

endmodule

// File: rtl/flopoco_fcmp_pipe.sv
// Two-stage FloPoCo float comparator with runtime predicate and tag.
// Optional FCMP_MINMAX_EN adds registered out_min/out_max.
module flopoco_fcmp_pipe
  import flopoco_fp_pkg::*;
#(
  parameter int WE    = 4,
  parameter int WF    = 4,
  parameter int TAG_W = 8,
  parameter int ID    = 1
) (
  input logic clk,
  input logic rst,
  flopoco_fcmp_pipe_if.slave io
);

  localparam int MW = WE + WF;
  localparam int N  = MW + 3;

  if (WE < 2 || WF < 1 || TAG_W < 1 || ID < 0) begin : g_param_chk
    $error("flopoco_fcmp_pipe: illegal parameters");
  end

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv      = ~s2_valid | io.out_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign io.in_ready = s1_adv & ~rst;

  logic [MW-1:0] x_mag, y_mag;
  logic          lt_mag, gt_mag;
  fcmp_dec_t     dec_in;

  assign x_mag = MW'(fp_mag(fp_raw_t'(io.X), WE, WF));
  assign y_mag = MW'(fp_mag(fp_raw_t'(io.Y), WE, WF));

  flopoco_mag_cmp #(.W(MW)) u_mag (
    .a (x_mag),
    .b (y_mag),
    .lt(lt_mag),
    .gt(gt_mag)
  );

  always_comb begin
    dec_in        = '0;
    dec_in.exc_x  = fp_exc(fp_raw_t'(io.X), WE, WF);
    dec_in.exc_y  = fp_exc(fp_raw_t'(io.Y), WE, WF);
    dec_in.sign_x = fp_sign(fp_raw_t'(io.X), WE, WF);
    dec_in.sign_y = fp_sign(fp_raw_t'(io.Y), WE, WF);
    dec_in.lt     = lt_mag;
    dec_in.gt     = gt_mag;
  end

  fcmp_dec_t        s1_dec;
  fcmp_op_e         s1_op;
  logic [TAG_W-1:0] s1_tag;
`ifdef FCMP_MINMAX_EN
  logic [N-1:0]     s1_x, s1_y;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dec   <= '0;
      s1_op    <= OP_EQ;
      s1_tag   <= '0;
`ifdef FCMP_MINMAX_EN
      s1_x     <= '0;
      s1_y     <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_dec <= dec_in;
        s1_op  <= io.op;
        s1_tag <= io.in_tag;
`ifdef FCMP_MINMAX_EN
        s1_x   <= io.X;
        s1_y   <= io.Y;
`endif
      end
    end
  end

  logic zx, zy, nx, ny, ix, iy, qx, qy;
  logic sx, sy, eq_mag, unord;
  logic eqnum, ltnum, gtnum, pred;

  always_comb begin
    zx     = s1_dec.exc_x == EXC_ZERO;
    zy     = s1_dec.exc_y == EXC_ZERO;
    nx     = s1_dec.exc_x == EXC_NORM;
    ny     = s1_dec.exc_y == EXC_NORM;
    ix     = s1_dec.exc_x == EXC_INF;
    iy     = s1_dec.exc_y == EXC_INF;
    qx     = s1_dec.exc_x == EXC_NAN;
    qy     = s1_dec.exc_y == EXC_NAN;
    sx     = s1_dec.sign_x;
    sy     = s1_dec.sign_y;
    eq_mag = ~s1_dec.lt & ~s1_dec.gt;
    unord  = qx | qy;
    eqnum  = (zx & zy)
           | ((nx & ny | ix & iy) & (sx == sy) & (ix | eq_mag));
    // Five terms: normal/normal, -inf on X, +inf on Y, zero vs normal
    ltnum  = (nx & ny & ((~sx & ~sy & s1_dec.lt) | (sx & ~sy)
                        | (sx & sy & s1_dec.gt)))
           | (ix & sx & ~(iy & sy))
           | (iy & ~sy & ~(ix & ~sx))
           | (zx & ny & ~sy)
           | (nx & sx & zy);
    gtnum  = (nx & ny & ((~sx & ~sy & s1_dec.gt) | (~sx & sy)
                        | (sx & sy & s1_dec.lt)))
           | (iy & sy & ~(ix & sx))
           | (ix & ~sx & ~(iy & ~sy))
           | (zy & nx & ~sx)
           | (ny & sy & zx);
    pred = 1'b0;
    unique case (s1_op)
      OP_EQ:    pred = eqnum & ~unord;
      OP_LT:    pred = ltnum & ~unord;
      OP_LE:    pred = (ltnum | eqnum) & ~unord;
      OP_GT:    pred = gtnum & ~unord;
      OP_GE:    pred = (gtnum | eqnum) & ~unord;
      OP_NE:    pred = ~(eqnum & ~unord);
      OP_UNORD: pred = unord;
      OP_ORD:   pred = ~unord;
      default:  pred = 1'b0;
    endcase
  end

`ifdef FCMP_MINMAX_EN
  logic [N-1:0] mm_min, mm_max;
  logic         x_below;

  // Signed zeros are ordered here so min/max stay deterministic
  always_comb begin
    x_below = ltnum | (zx & zy & sx & ~sy);
    mm_min  = x_below ? s1_x : s1_y;
    mm_max  = x_below ? s1_y : s1_x;
    if (qx & qy) begin
      mm_min = {EXC_NAN, {(N-2){1'b0}}};
      mm_max = {EXC_NAN, {(N-2){1'b0}}};
    end else if (qx) begin
      mm_min = s1_y;
      mm_max = s1_y;
    end else if (qy) begin
      mm_min = s1_x;
      mm_max = s1_x;
    end
  end
`endif

  logic             s2_result, s2_unord;
  logic [TAG_W-1:0] s2_tag;
`ifdef FCMP_MINMAX_EN
  logic [N-1:0]     s2_min, s2_max;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= 1'b0;
      s2_unord  <= 1'b0;
      s2_tag    <= '0;
`ifdef FCMP_MINMAX_EN
      s2_min    <= '0;
      s2_max    <= '0;
`endif
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= pred;
        s2_unord  <= unord;
        s2_tag    <= s1_tag;
`ifdef FCMP_MINMAX_EN
        s2_min    <= mm_min;
        s2_max    <= mm_max;
`endif
      end
    end
  end

  assign io.out_valid = s2_valid;
  assign io.result    = s2_result;
  assign io.unordered = s2_unord;
  assign io.out_tag   = s2_tag;
`ifdef FCMP_MINMAX_EN
  assign io.out_min   = s2_min;
  assign io.out_max   = s2_max;
`endif

endmodule

// File: tb/tb_flopoco_fcmp_pipe.sv
// Scoreboard bench for flopoco_fcmp_pipe (WE=4, WF=4, TAG_W=8).
module tb_flopoco_fcmp_pipe;
  import flopoco_fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flopoco_fcmp_pipe_if #(.WE(4), .WF(4), .TAG_W(8)) io ();

  flopoco_fcmp_pipe #(.WE(4), .WF(4), .TAG_W(8), .ID(1)) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  typedef struct {
    logic [7:0]  tag;
    logic        res;
    logic        un;
    logic [10:0] mn;
    logic [10:0] mx;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rmode = 0;
  int   n_fl  = 0;
  logic [7:0] tag_ctr = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, got, want, $time);
    end
  endtask

  // Total-order key for ordered values; +0 and -0 share a key
  function automatic int key(input logic [10:0] v);
    int m;
    m = int'(v[7:0]) + 1;
    case (v[10:9])
      2'b00:   return 0;
      2'b01:   return v[8] ? -m : m;
      default: return v[8] ? -1000 : 1000;
    endcase
  endfunction

  function automatic exp_t model(input logic [10:0] x, input logic [10:0] y,
                                 input fcmp_op_e o, input logic [7:0] t);
    exp_t e;
    bit nx, ny, nan, eq, lt, gt;
    int kx, ky, mx_k, my_k;
    nx  = x[10:9] == 2'b11;
    ny  = y[10:9] == 2'b11;
    nan = nx | ny;
    kx  = key(x);
    ky  = key(y);
    eq  = !nan && kx == ky;
    lt  = !nan && kx < ky;
    gt  = !nan && kx > ky;
    e.tag = t;
    e.un  = nan;
    e.acc = 0;
    e.lat = 0;
    case (o)
      OP_EQ:    e.res = eq;
      OP_LT:    e.res = lt;
      OP_LE:    e.res = lt | eq;
      OP_GT:    e.res = gt;
      OP_GE:    e.res = gt | eq;
      OP_NE:    e.res = !eq;
      OP_UNORD: e.res = nan;
      default:  e.res = !nan;
    endcase
    mx_k = kx * 2 + ((x[10:9] == 2'b00 && !x[8]) ? 1 : 0);
    my_k = ky * 2 + ((y[10:9] == 2'b00 && !y[8]) ? 1 : 0);
    if (nx && ny) begin
      e.mn = 11'h600;
      e.mx = 11'h600;
    end else if (nx) begin
      e.mn = y;
      e.mx = y;
    end else if (ny) begin
      e.mn = x;
      e.mx = x;
    end else begin
      e.mn = (mx_k < my_k) ? x : y;
      e.mx = (mx_k < my_k) ? y : x;
    end
    return e;
  endfunction

  task automatic send(input logic [10:0] x, input logic [10:0] y,
                      input fcmp_op_e o);
    exp_t e;
    bit   ok;
    int   w;
    e = model(x, y, o, tag_ctr);
    e.lat = (rmode == 0);
    io.X = x;
    io.Y = y;
    io.op = o;
    io.in_tag = tag_ctr;
    io.in_valid = 1'b1;
    ok = 0;
    w = 0;
    while (!ok && w < 200) begin
      @(negedge clk);
      ok = io.in_ready;
      if (!ok) begin
        w++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) chk("accept_timeout", 32'(io.in_ready), 32'd1);
    else begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    tag_ctr++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    io.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    io.in_valid = 1'b0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [10:0] rnd_val();
    logic [1:0] e;
    logic       s;
    logic [7:0] ef;
    e  = 2'($urandom_range(0, 3));
    s  = 1'($urandom_range(0, 1));
    ef = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h6E, 8'h72))
                                     : 8'($urandom_range(0, 255));
    if (e != 2'b01) begin
      ef = 8'h00;
      if (e == 2'b11) s = 1'b0;
    end
    return {e, s, ef};
  endfunction

  // out_ready shaping: 0 always, 1 pattern 1,0,0,1, 2 random
  initial begin
    int k;
    int pat[4];
    pat = '{1, 0, 0, 1};
    k = 0;
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       io.out_ready = 1'b1;
        1: begin
          io.out_ready = 1'(pat[k % 4]);
          k++;
        end
        default: io.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bit         hold_v;
    logic       h_res;
    logic [7:0] h_tag;
    exp_t       e;
    hold_v = 0;
    h_res  = 0;
    h_tag  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_fl   = 0;
        hold_v = 0;
      end else begin
        chk("in_ready", 32'(io.in_ready),
            32'(!(n_fl == 2 && !io.out_ready)));
        if (hold_v) begin
          chk("hold_valid", 32'(io.out_valid), 32'd1);
          chk("hold_tag", 32'(io.out_tag), 32'(h_tag));
          chk("hold_result", 32'(io.result), 32'(h_res));
        end
        hold_v = io.out_valid && !io.out_ready;
        h_tag  = io.out_tag;
        h_res  = io.result;
        if (io.out_valid && io.out_ready) begin
          if (sb.size() == 0) chk("spurious_out_valid", 32'(io.out_valid), 32'd0);
          else begin
            e = sb.pop_front();
            chk("out_tag", 32'(io.out_tag), 32'(e.tag));
            chk("result", 32'(io.result), 32'(e.res));
            chk("unordered", 32'(io.unordered), 32'(e.un));
            if (e.lat) chk("latency", 32'(cyc - e.acc + 1), 32'd2);
`ifdef FCMP_MINMAX_EN
            chk("out_min", 32'(io.out_min), 32'(e.mn));
            chk("out_max", 32'(io.out_max), 32'(e.mx));
`endif
          end
        end
        n_fl = n_fl + ((io.in_valid && io.in_ready) ? 1 : 0)
                    - ((io.out_valid && io.out_ready) ? 1 : 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    io.in_valid = 1'b0;
    io.X = '0;
    io.Y = '0;
    io.op = OP_EQ;
    io.in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_result", 32'(io.result), 32'd0);
    chk("rst_unordered", 32'(io.unordered), 32'd0);
    chk("rst_out_tag", 32'(io.out_tag), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);

    rmode = 0;
    tag_ctr = 8'h5A;
    send(11'h270, 11'h280, OP_LT);
    drain();
    send(11'h000, 11'h100, OP_EQ);
    send(11'h000, 11'h100, OP_LT);
    send(11'h600, 11'h270, OP_EQ);
    send(11'h600, 11'h270, OP_LT);
    send(11'h600, 11'h270, OP_NE);
    send(11'h600, 11'h270, OP_UNORD);
    send(11'h370, 11'h500, OP_GT);
    send(11'h400, 11'h400, OP_GE);
    send(11'h370, 11'h270, OP_LE);
    send(11'h500, 11'h000, OP_ORD);
`ifdef FCMP_MINMAX_EN
    send(11'h600, 11'h370, OP_LT);
    send(11'h600, 11'h600, OP_EQ);
    send(11'h100, 11'h000, OP_LT);
`endif
    drain();

    rmode = 1;
    for (int i = 0; i < 8; i++)
      send(rnd_val(), rnd_val(), fcmp_op_e'(i));
    drain();

    rmode = 2;
    for (int i = 0; i < 80; i++) begin
      send(rnd_val(), rnd_val(), fcmp_op_e'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    rmode = 0;
    idle(2);
    send(11'h270, 11'h280, OP_LT);
    send(11'h280, 11'h270, OP_GT);
    io.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_flush_out_valid", 32'(io.out_valid), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(io.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(11'h370, 11'h270, OP_LT);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
